// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: loader state encoding and instruction word type, shared
// with the instruction memory and fetch logic.
`default_nettype none

package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } ld_state_t;

  typedef logic [31:0] instr_t;

  localparam int unsigned BYTES_PER_WORD = 4;

endpackage

`default_nettype wire

// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed byte stream and writes it into
// instruction memory as little-endian 32-bit words, holding the core in reset
// until the load completes.
`default_nettype none

module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output instr_t            imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_rst_n,
  output logic [ADDR_W:0]   words_written
);

  ld_state_t         r_state;
  ld_state_t         w_state_nxt;
  logic [7:0]        r_n;
  logic [23:0]       r_word;
  logic [1:0]        r_bidx;
  logic [ADDR_W:0]   r_ww;
  logic [ADDR_W-1:0] r_addr;
  instr_t            r_wdata;
  logic              r_cpu_rst_n;

  logic            w_xfer;
  logic            w_start_ok;
  logic            w_last_byte;
  logic [ADDR_W:0] w_ww_inc;

  assign w_xfer      = s_valid && s_ready;
  assign w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                 (r_state == ST_ERR));
  assign w_last_byte = (r_bidx == 2'(BYTES_PER_WORD - 1));
  assign w_ww_inc    = r_ww + (ADDR_W+1)'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    s_ready     = 1'b0;
    imem_we     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_HDR;
      ST_DONE: begin
        done = 1'b1;
        if (start) w_state_nxt = ST_HDR;
      end
      ST_ERR: begin
        err = 1'b1;
        if (start) w_state_nxt = ST_HDR;
      end
      ST_HDR: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (w_xfer) begin
          if (s_data == 8'd0)                    w_state_nxt = ST_DONE;
          else if (32'(s_data) > 32'(DEPTH))     w_state_nxt = ST_ERR;
          else                                   w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (w_xfer && w_last_byte) w_state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        imem_we = 1'b1;
        busy    = 1'b1;
        if (32'(w_ww_inc) == 32'(r_n)) w_state_nxt = ST_DONE;
        else                           w_state_nxt = ST_DATA;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The write address/data are captured on the 4th byte so they are stable
  // throughout WRITE and hold afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n         <= 8'd0;
      r_word      <= 24'd0;
      r_bidx      <= 2'd0;
      r_ww        <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_rst_n <= 1'b0;
    end else begin
      r_cpu_rst_n <= (w_state_nxt == ST_DONE);
      if (w_start_ok) begin
        r_bidx <= 2'd0;
        r_ww   <= '0;
      end
      if ((r_state == ST_HDR) && w_xfer) r_n <= s_data;
      if ((r_state == ST_DATA) && w_xfer) begin
        r_word <= {s_data, r_word[23:8]};
        r_bidx <= r_bidx + 2'd1;
        if (w_last_byte) begin
          r_addr  <= r_ww[ADDR_W-1:0];
          r_wdata <= {s_data, r_word};
        end
      end
      if (r_state == ST_WRITE) begin
        r_ww   <= w_ww_inc;
        r_bidx <= 2'd0;
      end
    end
  end

  assign imem_addr     = r_addr;
  assign imem_wdata    = r_wdata;
  assign cpu_rst_n     = r_cpu_rst_n;
  assign words_written = r_ww;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized loads against a byte-stream model; a monitor
// scores every memory write against the expected-write queue.
`default_nettype none

module tb_imem_loader;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        s_data = 8'd0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy, done, err, cpu_rst_n;
  logic [ADDR_W:0]   words_written;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy), .done(done), .err(err),
    .cpu_rst_n(cpu_rst_n), .words_written(words_written)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] bytes[$];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && imem_we) begin
        chk("ready_in_write", 32'(s_ready), 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_write_addr", 32'(imem_addr), 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("write_addr", 32'(imem_addr), e.a);
          chk("write_data", imem_wdata, e.d);
        end
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rnd, input bit pulse);
    bit x;
    int g;
    g = 0;
    s_data = b;
    do begin
      s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start   = pulse ? ($urandom_range(0, 3) == 0) : 1'b0;
      @(negedge clk);
      x = s_valid && s_ready;
      @(posedge clk); #1;
      g++;
    end while (!x && g < 300);
    s_valid = 1'b0;
    start   = 1'b0;
    if (!x) chk("xfer_timeout", 32'(x), 32'd1);
  endtask

  task automatic wait_end(output int t);
    t = 0;
    @(negedge clk);
    while (!(done || err) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("end_timeout", 32'(t), 32'd0);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] word_of(input int w);
    return {bytes[4*w+3], bytes[4*w+2], bytes[4*w+1], bytes[4*w]};
  endfunction

  task automatic fill_random(input int n);
    bytes.delete();
    for (int i = 0; i < 4 * n; i++) bytes.push_back(8'($urandom));
  endtask

  // Full load of n words from the bytes queue, then end-state checks.
  task automatic load(input int n, input bit rnd, input bit pulse);
    int t;
    pulse_start();
    chk("hdr_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("hdr_busy", 32'(busy), 32'd1);
    send_byte(8'(n), rnd, pulse);
    if (n > DEPTH) begin
      wait_end(t);
      chk("err_flag", 32'(err), 32'd1);
      chk("err_done", 32'(done), 32'd0);
      chk("err_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      chk("err_ww", 32'(words_written), 32'd0);
      return;
    end
    for (int w = 0; w < n; w++) begin
      wr_t e;
      e.a = 32'(w);
      e.d = word_of(w);
      exp_q.push_back(e);
      for (int k = 0; k < 4; k++) send_byte(bytes[4*w+k], rnd, pulse);
    end
    wait_end(t);
    if (n == 0) chk("n0_latency", 32'(t), 32'd0);
    chk("done_flag", 32'(done), 32'd1);
    chk("done_err", 32'(err), 32'd0);
    chk("done_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    chk("done_ww", 32'(words_written), 32'(n));
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    chk({tag, "_imem_we"}, 32'(imem_we), 32'd0);
    chk({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
    chk({tag, "_imem_wdata"}, imem_wdata, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
    chk({tag, "_ww"}, 32'(words_written), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("por");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fixed two-word program.
    bytes.delete();
    bytes = '{8'h80, 8'h81, 8'h00, 8'h00, 8'hB2, 8'h2C, 8'h00, 8'h00};
    load(2, 1'b0, 1'b0);

    // Empty program, oversized header, then recovery.
    load(0, 1'b0, 1'b0);
    load(33, 1'b0, 1'b0);
    fill_random(1);
    load(1, 1'b0, 1'b0);

    // Single word with a randomly stalling source.
    fill_random(1);
    load(1, 1'b1, 1'b0);

    // Reset after the 2nd byte of word 1.
    fill_random(2);
    pulse_start();
    send_byte(8'd2, 1'b1, 1'b0);
    begin
      wr_t e;
      e.a = 32'd0;
      e.d = word_of(0);
      exp_q.push_back(e);
    end
    for (int k = 0; k < 6; k++) send_byte(bytes[k], 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("midrst");
    chk("midrst_pending", 32'(exp_q.size()), 32'd0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    fill_random(3);
    load(3, 1'b1, 1'b0);

    // Full-depth load with stray start pulses while busy.
    fill_random(DEPTH);
    load(DEPTH, 1'b1, 1'b1);

    // Random headers, including out-of-range values.
    for (int r = 0; r < 6; r++) begin
      int n;
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(DEPTH + 1, 255))
                                      : int'($urandom_range(0, DEPTH));
      fill_random(n > DEPTH ? 0 : n);
      load(n, 1'b1, 1'b0);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 32: instruction memory depth in 32-bit words.
REQ-002 Parameter ADDR_W, default 5: instruction memory word-address width; $clog2(DEPTH).
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
REQ-007 s_data  input  8  inbound program byte.
REQ-008 s_valid  input  1  s_data valid.
REQ-009 s_ready  output  1  loader accepts a byte; a transfer occurs when s_valid and s_ready are both 1 at a clk edge.
REQ-010 imem_we  output  1  instruction memory write strobe, one cycle per word.
REQ-011 imem_addr  output  ADDR_W  word address of the write.
REQ-012 imem_wdata  output  32  word being written.
REQ-013 busy  output  1  high in HDR, DATA and WRITE.
REQ-014 done  output  1  high in DONE.
REQ-015 err  output  1  high in ERR.
REQ-016 cpu_rst_n  output  1  core reset; low in every state except DONE.
REQ-017 words_written  output  ADDR_W+1  count of words committed in the current load.

Function
REQ-018 States: IDLE, HDR, DATA, WRITE, DONE, ERR.
REQ-019 IDLE/DONE/ERR with start=1 -> HDR next cycle; word counter, byte index and words_written clear to 0; err and done drop in the same cycle.
REQ-020 HDR: s_ready=1; on transfer, latch N=s_data; N=0 -> DONE; N>DEPTH -> ERR; else -> DATA.
REQ-021 DATA: s_ready=1; bytes are assembled little-endian (first byte into bits 7:0); after the 4th transfer -> WRITE.
REQ-022 WRITE: s_ready=0; imem_we=1 for exactly one cycle; imem_addr=word counter; imem_wdata=assembled word.
REQ-023 On leaving WRITE, words_written increments; if it then equals N -> DONE, else -> DATA with byte index 0.
REQ-024 Each accepted word reaches imem_we 1 cycle after its 4th byte transfer; peak throughput is 1 word per 5 cycles.
REQ-025 s_valid=0 stalls HDR/DATA indefinitely, with no state change and no memory write.
REQ-026 Outside IDLE/DONE/ERR, start is ignored; a load is never restarted mid-word.
REQ-027 imem_we=0 in every state other than WRITE; imem_addr and imem_wdata hold their last value when imem_we=0.
REQ-028 cpu_rst_n is registered; it rises on the cycle DONE is entered and falls on the cycle HDR is entered.
REQ-029 The word counter never exceeds DEPTH-1 because of the N check; no address wrap occurs.

Reset
REQ-030 rst_n=0 forces state IDLE immediately and asynchronously, including mid-load.
REQ-031 Reset values: s_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err=0, cpu_rst_n=0, words_written=0.
REQ-032 Words written before a mid-load reset remain in memory; the loader makes no rollback.

Structure
REQ-033 A shared package holds the state enum and a 32-bit instruction word typedef, for reuse by instruction memory and fetch.
REQ-034 The design is a single module with no sub-module; the byte assembler is an inline shift register.
REQ-035 The instruction memory gains a synchronous write port (we, addr, wdata) driven by this block, with its combinational read port unchanged.

Verification
REQ-036 Scenario: start, N=2, bytes 80 81 00 00 B2 2C 00 00 -> imem_we at addr 0 with 0x00008180, then at addr 1 with 0x00002CB2; done=1, cpu_rst_n=1, words_written=2.
REQ-037 Scenario: start, N=0 -> DONE on the cycle after the header transfer; no imem_we pulse.
REQ-038 Scenario: start, N=33 (DEPTH=32) -> err=1, cpu_rst_n=0, no write; a second start with N=1 recovers to done.
REQ-039 Scenario: N=1 with s_valid toggled randomly -> exactly one imem_we pulse with the correct word; s_ready=0 during WRITE.
REQ-040 Scenario: rst_n asserted after the 2nd byte of word 1 -> all outputs at reset values asynchronously; a fresh start loads correctly from addr 0.
REQ-041 Scenario: N=32 full load -> last write at addr 31; start pulses during busy are ignored.
